// File: rtl/galaga_btn_ctrl.sv
// Button front-end for the GALAGA game timer: synchronizes and debounces the raw
// active-low start/stop buttons and produces press pulses plus a stop long-press pulse.
module galaga_btn_ctrl #(
  parameter int unsigned DEB_CLK  = 100_000_000 / 100 - 1,
  parameter int unsigned LONG_CLK = 100_000_000 - 1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_BtnStart,
  input  logic i_BtnStop,
  output logic o_fStart,
  output logic o_fStop,
  output logic o_StartPls,
  output logic o_StopPls,
  output logic o_LongPls
);

  localparam int unsigned CNT_W     = 20;
  localparam int unsigned LCNT_W    = 27;
  localparam int unsigned NBTN      = 2;
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_STOP  = 1;

  typedef enum logic [1:0] {
    ST_REL,
    ST_PWAIT,
    ST_PRS,
    ST_RWAIT
  } btn_state_e;

  logic [NBTN-1:0]   sync1_q, sync2_q;
  btn_state_e        state_q [NBTN];
  btn_state_e        state_d [NBTN];
  logic [CNT_W-1:0]  cnt_q   [NBTN];
  logic [CNT_W-1:0]  cnt_d   [NBTN];
  logic [NBTN-1:0]   lvl_q, lvl_d;
  logic [NBTN-1:0]   press_c;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              long_done_q, long_done_d;
  logic              start_pls_q, start_pls_d;
  logic              stop_pls_q, stop_pls_d;
  logic              long_pls_q, long_pls_d;

  // Two-flop synchronizer; idle (released) level is 1.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {i_BtnStop, i_BtnStart};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int b = 0; b < int'(NBTN); b++) begin
        state_q[b] <= ST_REL;
        cnt_q[b]   <= '0;
      end
      lvl_q       <= '1;
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      start_pls_q <= 1'b0;
      stop_pls_q  <= 1'b0;
      long_pls_q  <= 1'b0;
    end else begin
      for (int b = 0; b < int'(NBTN); b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      lvl_q       <= lvl_d;
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      start_pls_q <= start_pls_d;
      stop_pls_q  <= stop_pls_d;
      long_pls_q  <= long_pls_d;
    end
  end

  // Per-button debounce FSM: a level change needs DEB_CLK+1 stable samples after leaving REL/PRS.
  always_comb begin
    lvl_d   = lvl_q;
    press_c = '0;
    for (int b = 0; b < int'(NBTN); b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      unique case (state_q[b])
        ST_REL: begin
          if (!sync2_q[b]) begin
            state_d[b] = ST_PWAIT;
            cnt_d[b]   = '0;
          end
        end
        ST_PWAIT: begin
          if (sync2_q[b]) begin
            state_d[b] = ST_REL;
            cnt_d[b]   = '0;
          end else if (cnt_q[b] == CNT_W'(DEB_CLK)) begin
            state_d[b] = ST_PRS;
            cnt_d[b]   = '0;
            lvl_d[b]   = 1'b0;
            press_c[b] = 1'b1;
          end else begin
            cnt_d[b] = cnt_q[b] + CNT_W'(1);
          end
        end
        ST_PRS: begin
          if (sync2_q[b]) begin
            state_d[b] = ST_RWAIT;
            cnt_d[b]   = '0;
          end
        end
        ST_RWAIT: begin
          if (!sync2_q[b]) begin
            state_d[b] = ST_PRS;
            cnt_d[b]   = '0;
          end else if (cnt_q[b] == CNT_W'(DEB_CLK)) begin
            state_d[b] = ST_REL;
            cnt_d[b]   = '0;
            lvl_d[b]   = 1'b1;
          end else begin
            cnt_d[b] = cnt_q[b] + CNT_W'(1);
          end
        end
        default: begin
          state_d[b] = ST_REL;
          cnt_d[b]   = '0;
        end
      endcase
    end
  end

  // Long-press timer: counts only in PRS, holds across a release bounce, fires once per press.
  always_comb begin
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    long_pls_d  = 1'b0;
    if (state_q[BTN_STOP] == ST_PRS) begin
      if (lcnt_q < LCNT_W'(LONG_CLK)) begin
        lcnt_d = lcnt_q + LCNT_W'(1);
      end else if (!long_done_q) begin
        long_pls_d  = 1'b1;
        long_done_d = 1'b1;
      end
    end
    if (state_d[BTN_STOP] == ST_REL || state_d[BTN_STOP] == ST_PWAIT) begin
      lcnt_d      = '0;
      long_done_d = 1'b0;
    end
  end

  // Stop wins when both presses are accepted on the same edge.
  always_comb begin
    start_pls_d = press_c[BTN_START] & ~press_c[BTN_STOP];
    stop_pls_d  = press_c[BTN_STOP];
  end

  assign o_fStart   = lvl_q[BTN_START];
  assign o_fStop    = lvl_q[BTN_STOP];
  assign o_StartPls = start_pls_q;
  assign o_StopPls  = stop_pls_q;
  assign o_LongPls  = long_pls_q;

endmodule
